// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational ALU between the core execute
// path (port 0) and the address/CSR unit (port 1), one operation in flight at a time.
module alu_share_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] req_a_0,
    input  logic [WIDTH-1:0] req_a_1,
    input  logic [WIDTH-1:0] req_b_0,
    input  logic [WIDTH-1:0] req_b_1,
    input  logic [3:0]       req_ctrl_0,
    input  logic [3:0]       req_ctrl_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    input  logic             rsp_ready_0,
    input  logic             rsp_ready_1,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    localparam int unsigned CTRL_W   = 4;
    localparam logic [CTRL_W-1:0] CTRL_MAX = CTRL_W'(4'b1001);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              last_grant;

    logic              any_req_c;
    logic              grant_c;
    logic              accept_c;
    logic              illegal_c;
    logic              rsp_hs_c;
    logic [WIDTH-1:0]  sel_a_c;
    logic [WIDTH-1:0]  sel_b_c;
    logic [CTRL_W-1:0] sel_ctrl_c;

    // Round-robin pick: on a tie the port that did not win last time goes first.
    always_comb begin
        any_req_c = req_valid_0 | req_valid_1;
        grant_c   = 1'b0;
        if (req_valid_0 && req_valid_1) begin
            grant_c = ~last_grant;
        end else if (req_valid_1) begin
            grant_c = 1'b1;
        end
    end

    always_comb begin
        sel_a_c    = grant_c ? req_a_1    : req_a_0;
        sel_b_c    = grant_c ? req_b_1    : req_b_0;
        sel_ctrl_c = grant_c ? req_ctrl_1 : req_ctrl_0;
        illegal_c  = (sel_ctrl_c > CTRL_MAX);
        accept_c   = (state == IDLE) && any_req_c;
        rsp_hs_c   = (state == RESP) && (owner ? rsp_ready_1 : rsp_ready_0);
    end

    assign req_ready_0 = accept_c && !grant_c;
    assign req_ready_1 = accept_c &&  grant_c;
    assign rsp_valid_0 = (state == RESP) && !owner;
    assign rsp_valid_1 = (state == RESP) &&  owner;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt = illegal_c ? RESP : ISSUE;
                end
            end
            ISSUE: state_nxt = RESP;
            RESP: begin
                if (rsp_hs_c) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operand registers double as the request capture; they are non-zero only in ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_data   <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (accept_c) begin
                owner      <= grant_c;
                last_grant <= grant_c;
                if (illegal_c) begin
                    rsp_data <= '0;
                    rsp_zero <= 1'b0;
                    rsp_err  <= 1'b1;
                end else begin
                    alu_a    <= sel_a_c;
                    alu_b    <= sel_b_c;
                    alu_ctrl <= sel_ctrl_c;
                end
            end
            if (state == ISSUE) begin
                rsp_data <= alu_result;
                rsp_zero <= (alu_result == '0);
                rsp_err  <= 1'b0;
                alu_a    <= '0;
                alu_b    <= '0;
                alu_ctrl <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares them on every response handshake.
module tb_alu_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
    logic [3:0]  req_ctrl_0, req_ctrl_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic        rsp_ready_0, rsp_ready_1;
    logic [31:0] rsp_data;
    logic        rsp_zero, rsp_err;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl;
    logic        busy;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .req_a_0(req_a_0), .req_a_1(req_a_1),
        .req_b_0(req_b_0), .req_b_1(req_b_1),
        .req_ctrl_0(req_ctrl_0), .req_ctrl_1(req_ctrl_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the shared datapath ALU.
    always_comb begin
        case (alu_ctrl)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a & alu_b;
            4'b0011: alu_result = alu_a | alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b0110: alu_result = alu_a >> alu_b[4:0];
            4'b0111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            4'b1000: alu_result = alu_a << alu_b[4:0];
            4'b1001: alu_result = {31'd0, alu_a < alu_b};
            default: alu_result = 32'd0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if ((rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {31'd0, rsp_valid_1}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_port", {31'd0, rsp_valid_1}, {31'd0, e.port});
                    chk("rsp_data", rsp_data, e.data);
                    chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
                    chk("rsp_err",  {31'd0, rsp_err},  {31'd0, e.err});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] c);
        if (p == 0) begin
            req_valid_0 = v; req_a_0 = a; req_b_0 = b; req_ctrl_0 = c;
        end else begin
            req_valid_1 = v; req_a_1 = a; req_b_1 = b; req_ctrl_1 = c;
        end
    endtask

    task automatic push(input logic p, input logic [31:0] d, input logic z, input logic e);
        exp_t x;
        x.port = p; x.data = d; x.zero = z; x.err = e;
        exp_q.push_back(x);
    endtask

    // Returns the accepted port (or -1 on timeout) and the cycle of the handshake.
    task automatic wait_accept(output int p, output int at);
        p  = -1;
        at = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_valid_0 && req_ready_0) begin p = 0; break; end
            if (req_valid_1 && req_ready_1) begin p = 1; break; end
        end
        at = cyc;
        if (p < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_timeout: got no accept expected one within 20 cycles");
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 30; n++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        int p, at, prev, h;
        int idx [2];
        logic [31:0] ops_a [2][2];
        logic [31:0] ops_b [2][2];
        logic [3:0]  ops_c [2][2];

        rst_n = 1'b0;
        req_valid_0 = 0; req_valid_1 = 0;
        req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
        req_ctrl_0 = 0; req_ctrl_1 = 0;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        #2;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single add on port 0
        push(1'b0, 32'd12, 1'b0, 1'b0);
        set_req(0, 1, 32'd5, 32'd7, 4'b0000);
        wait_accept(p, at);
        chk("t1_grant", p, 0);
        chk("t1_ready1", {31'd0, req_ready_1}, 0);
        tick();
        req_valid_0 = 0;
        @(negedge clk);
        chk("t1_issue_a", alu_a, 5);
        chk("t1_issue_b", alu_b, 7);
        chk("t1_issue_ctrl", {28'd0, alu_ctrl}, 0);
        @(negedge clk);
        chk("t1_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd1);
        chk("t1_alu_cleared", alu_a, 0);
        tick();

        // Zero result on port 1
        push(1'b1, 32'd0, 1'b1, 1'b0);
        set_req(1, 1, 32'd9, 32'd9, 4'b0001);
        wait_accept(p, at);
        chk("t2_grant", p, 1);
        tick();
        req_valid_1 = 0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd2);
        tick();

        // Continuous contention: grants alternate 0,1,0,1 three cycles apart
        ops_a[0][0] = 32'd1;  ops_b[0][0] = 32'd2;  ops_c[0][0] = 4'b0000;
        ops_a[0][1] = 32'hF0; ops_b[0][1] = 32'h3C; ops_c[0][1] = 4'b0010;
        ops_a[1][0] = 32'h0F; ops_b[1][0] = 32'hF0; ops_c[1][0] = 4'b0011;
        ops_a[1][1] = 32'hFF; ops_b[1][1] = 32'h0F; ops_c[1][1] = 4'b0100;
        push(1'b0, 32'd3,   1'b0, 1'b0);
        push(1'b1, 32'hFF,  1'b0, 1'b0);
        push(1'b0, 32'h30,  1'b0, 1'b0);
        push(1'b1, 32'hF0,  1'b0, 1'b0);
        idx[0] = 0; idx[1] = 0; prev = 0;
        set_req(0, 1, ops_a[0][0], ops_b[0][0], ops_c[0][0]);
        set_req(1, 1, ops_a[1][0], ops_b[1][0], ops_c[1][0]);
        for (int k = 0; k < 4; k++) begin
            wait_accept(p, at);
            chk("t3_grant_order", p, k % 2);
            if (k > 0) chk("t3_spacing", at - prev, 3);
            prev = at;
            tick();
            if (p >= 0) begin
                idx[p]++;
                if (idx[p] < 2) set_req(p, 1, ops_a[p][idx[p]], ops_b[p][idx[p]], ops_c[p][idx[p]]);
                else set_req(p, 0, 0, 0, 0);
            end
        end
        wait_drain();
        tick();

        // Illegal control code: ALU never driven, response one cycle after accept
        push(1'b0, 32'd0, 1'b0, 1'b1);
        set_req(0, 1, 32'd3, 32'd4, 4'b1100);
        wait_accept(p, at);
        chk("t4_grant", p, 0);
        tick();
        req_valid_0 = 0;
        @(negedge clk);
        chk("t4_rsp_valid", {30'd0, rsp_valid_1, rsp_valid_0}, 32'd1);
        chk("t4_alu_a", alu_a, 0);
        chk("t4_alu_b", alu_b, 0);
        chk("t4_alu_ctrl", {28'd0, alu_ctrl}, 0);
        tick();

        // Back-pressure on port 0 while port 1 waits
        rsp_ready_0 = 0;
        push(1'b0, 32'h123, 1'b0, 1'b0);
        set_req(0, 1, 32'h100, 32'h23, 4'b0000);
        wait_accept(p, at);
        chk("t5_grant", p, 0);
        tick();
        req_valid_0 = 0;
        push(1'b1, 32'd15, 1'b0, 1'b0);
        set_req(1, 1, 32'd20, 32'd5, 4'b0001);
        @(negedge clk);
        chk("t5_ready1_issue", {31'd0, req_ready_1}, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t5_hold_valid", {31'd0, rsp_valid_0}, 1);
            chk("t5_hold_data", rsp_data, 32'h123);
            chk("t5_ready1_hold", {31'd0, req_ready_1}, 0);
        end
        tick();
        rsp_ready_0 = 1;
        @(negedge clk);
        h = cyc;
        wait_accept(p, at);
        chk("t5_grant1", p, 1);
        chk("t5_accept_cycle", at - h, 1);
        tick();
        req_valid_1 = 0;
        wait_drain();
        tick();

        // Reset during ISSUE drops the operation and restores port-0 tie priority
        set_req(0, 1, 32'd1, 32'd1, 4'b0000);
        wait_accept(p, at);
        chk("t6_grant", p, 0);
        tick();
        req_valid_0 = 0;
        @(negedge clk);
        chk("t6_issue_a", alu_a, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_alu_a", alu_a, 0);
        chk("t6_rst_rsp_data", rsp_data, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", {30'd0, rsp_valid_1, rsp_valid_0}, 0);
        end
        tick();
        push(1'b0, 32'd5,  1'b0, 1'b0);
        push(1'b1, 32'h10, 1'b0, 1'b0);
        set_req(0, 1, 32'd2, 32'd3, 4'b0000);
        set_req(1, 1, 32'd1, 32'd4, 4'b1000);
        wait_accept(p, at);
        chk("t6_tie_grant", p, 0);
        tick();
        req_valid_0 = 0;
        wait_accept(p, at);
        chk("t6_second_grant", p, 1);
        tick();
        req_valid_1 = 0;
        wait_drain();
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single datapath ALU between two requesters: port 0 is the core execute path and port 1 is the auxiliary address/CSR unit.
- Each request is accepted through a valid/ready handshake, and the arbiter registers its operands and 4-bit ALU control code.
- It drives the shared ALU for exactly one cycle, captures the result and returns it to the owning requester through a valid/ready response.
- Requesters are arbitrated round-robin, and at most one operation is in flight at a time.

Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_0 / req_valid_1  input  1  request valid, per requester.
- req_ready_0 / req_ready_1  output  1  request accepted this cycle when high together with valid.
- req_a_0 / req_a_1  input  WIDTH  operand A.
- req_b_0 / req_b_1  input  WIDTH  operand B.
- req_ctrl_0 / req_ctrl_1  input  4  ALU control code: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110/0111 shift-right variants, 1000 sll, 1001 sltu.
- rsp_valid_0 / rsp_valid_1  output  1  result valid for that requester.
- rsp_ready_0 / rsp_ready_1  input  1  requester takes the result.
- rsp_data  output  WIDTH  result, shared by both ports; meaningful only while a rsp_valid is high.
- rsp_zero  output  1  result == 0.
- rsp_err  output  1  illegal control code.
- alu_a  output  WIDTH  operand A to the shared ALU.
- alu_b  output  WIDTH  operand B to the shared ALU.
- alu_ctrl  output  4  ALUControl to the shared ALU.
- alu_result  input  WIDTH  combinational result from the ALU.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All req_ready, rsp_valid, rsp_err and busy outputs are 0.
  - rsp_data=0, rsp_zero=0.
  - alu_a=0, alu_b=0, alu_ctrl=0000.
  - An in-flight operation is dropped; no response is ever produced for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Grant is computed combinationally.
  - If only one request is valid, that port is granted.
  - If both are valid, the port != last_grant is granted.
  - req_ready is high only for the granted port; both are 0 if no request is valid.
  - On the handshake, the arbiter registers a, b, ctrl and owner, and sets last_grant=owner.
  - Next state is ISSUE for a legal ctrl.
  - For an illegal ctrl (1010–1111), next state is RESP with rsp_data=0, rsp_zero=0, rsp_err=1. The ALU is never driven for that request.
- ISSUE (exactly 1 cycle):
  - alu_a, alu_b and alu_ctrl carry the registered values.
  - At the clock edge, rsp_data<=alu_result, rsp_zero<=(alu_result==0), rsp_err<=0.
  - Next state is RESP.
- Outside ISSUE: alu_a=0, alu_b=0, alu_ctrl=0000.
- RESP:
  - rsp_valid_<owner>=1; the other rsp_valid stays 0.
  - rsp_data, rsp_zero and rsp_err are held stable until the owner's rsp_ready is high.
  - On that handshake, next state is IDLE.
  - The non-owner's rsp_ready is ignored.
- Latency and throughput:
  - Handshake in cycle N → ALU driven in N+1 → rsp_valid from N+2.
  - An illegal code gives rsp_valid from N+1.
  - Minimum spacing between accepts is 3 cycles.
- No request is accepted outside IDLE: both req_ready are 0.
- Requester inputs may change freely after the handshake; only the registered copies are used.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1.
- Simultaneous response handshake and new request: the new request is accepted no earlier than the cycle after returning to IDLE.
- Back-pressure: the arbiter may hold RESP indefinitely; there is no timeout.

Test Plan:
- Single add:
  - Stimulus: port 0 a=5, b=7, ctrl=0000.
  - Required: alu_ctrl=0000 exactly 1 cycle after accept; rsp_valid_0 at accept+2 with rsp_data=12, rsp_zero=0; rsp_valid_1 stays 0.
- Zero result:
  - Stimulus: port 1 sub, a=9, b=9.
  - Required: rsp_data=0, rsp_zero=1, only rsp_valid_1 high.
- Contention:
  - Stimulus: both ports hold valid continuously for 4 operations, with rsp_ready tied high.
  - Required: grant order is 0,1,0,1; accepts are 3 cycles apart.
- Illegal code:
  - Stimulus: port 0 ctrl=1100.
  - Required: ALU outputs stay 0/0000 throughout; rsp_valid_0 at accept+1 with rsp_err=1, rsp_data=0.
- Back-pressure:
  - Stimulus: hold rsp_ready_0=0 for 5 cycles, with port 1 valid meanwhile.
  - Required: rsp_data stays stable; req_ready_1=0 throughout; port 1 is accepted in the cycle after the response handshake.
- Reset mid-op:
  - Stimulus: assert rst_n=0 during ISSUE.
  - Required: outputs clear immediately; after release, no rsp_valid appears, and the next tie grants port 0.
